interrupt_controller: RTL
=========================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter NUM_IRQ, default 8: number of external interrupt lines, legal range 1..16.
REQ-002 Parameter VECTOR_BASE, default 16'h0010: instruction address of vector 0.
REQ-003 Parameter VECTOR_STRIDE, default 16'h0004: address distance between consecutive vectors.
REQ-004 Parameter MASK_ADDR, default 4'hF: I/O address of the mask register, compared against d_addr[3:0].
REQ-005 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 Port irq, input, NUM_IRQ: external interrupt request lines, rising-edge sensitive.
REQ-008 Port io_interrupt, output, 1: interrupt request to the CPU control unit.
REQ-009 Port io_store_retaddr, input, 1: CPU strobe; d_bus carries the return address.
REQ-010 Port io_push_retaddr, input, 1: CPU strobe; block drives the saved return address onto d_bus.
REQ-011 Port io_push_ints, input, 1: CPU strobe; block drives the pending vector onto d_bus.
REQ-012 Port io_push_int_addr, input, 1: CPU strobe; block drives the active vector address onto d_bus.
REQ-013 Port io_write, input, 1: I/O write strobe.
REQ-014 Port d_addr, input, 16: data address bus.
REQ-015 Port d_bus, inout, 16: shared data bus, tri-stated when the block is not driving it.

Function
REQ-016 Edge detect: pending[i] is set on any clock where irq_s[i]=1 and the previous sample of irq_s[i]=0 (irq_s is the synchronized or raw line, see Configuration).
REQ-017 Mask write: io_write=1 with d_addr[3:0]=MASK_ADDR loads mask <= d_bus[NUM_IRQ-1:0]; mask bit 1 enables that line.
REQ-018 FSM states IDLE, REQ, SERVICE; io_interrupt=1 only in REQ (registered output).
REQ-019 IDLE -> REQ when (pending & mask) != 0.
REQ-020 REQ -> IDLE when (pending & mask) becomes 0 (masked before acknowledge); no state saved.
REQ-021 REQ -> SERVICE on io_store_retaddr: latch retaddr <= d_bus; latch active_idx = lowest-numbered set bit of (pending & mask); clear pending[active_idx].
REQ-022 A new edge on irq[active_idx] in the same cycle as its clear leaves pending set (set wins).
REQ-023 SERVICE -> IDLE on io_push_retaddr; no nesting; new requests remain pending.
REQ-024 io_push_int_addr drives VECTOR_BASE + active_idx*VECTOR_STRIDE, mod 2^16.
REQ-025 io_push_ints drives pending zero-extended to 16 bits.
REQ-026 io_push_retaddr drives retaddr.
REQ-027 Multiple push strobes in one cycle: exactly one drives, priority push_retaddr > push_int_addr > push_ints.
REQ-028 Latency, irq edge to io_interrupt: 2 clocks (edge sampled -> pending next clock -> io_interrupt the clock after).
REQ-029 Strobes irrelevant to the current state (e.g. io_store_retaddr in IDLE) are ignored.

Reset
REQ-030 rst_n=0 asynchronously forces: state IDLE, io_interrupt 0, pending 0, mask 0, retaddr 0, active_idx 0, edge history 0, synchronizers 0, d_bus released to Z.
REQ-031 Reset asserted mid-service discards the request; after release, only fresh edges create pending bits.

Configuration
REQ-032 Macro IC_SYNC_EN defined: each irq line passes through a two-flop synchronizer before edge detection, and the latency in REQ-028 becomes 4 clocks.
REQ-033 IC_SYNC_EN undefined: irq lines feed edge detection directly; irq must be synchronous to clk.

Structure
REQ-034 Package ic_pkg holds the FSM state enum typedef (IDLE/REQ/SERVICE) and the default address and vector constants.
REQ-035 Sub-module ic_prio_enc: combinational lowest-index priority encoder producing an index and a valid bit.
REQ-036 Total RTL target is 120-400 lines.

Verification
REQ-037 Scenario 1: mask=8'h04; pulse irq[2] -> io_interrupt=1 two clocks later; io_store_retaddr with d_bus=16'h1234 -> io_interrupt=0; io_push_int_addr -> d_bus=16'h0018; io_push_retaddr -> d_bus=16'h1234, state IDLE.
REQ-038 Scenario 2: mask=8'hFF; irq[5] and irq[1] rise in the same cycle -> serviced index 1 (vector 16'h0014); io_push_ints -> d_bus=16'h0020.
REQ-039 Scenario 3: mask=0; pulse irq[3] -> no io_interrupt; io_push_ints -> 16'h0008; write mask=8'h08 -> io_interrupt within 2 clocks.
REQ-040 Scenario 4: enter REQ, then write mask=0 before acknowledge -> io_interrupt drops next clock, state IDLE, pending retained.
REQ-041 Scenario 5: irq[0] held high -> exactly one pending set; an edge in the clear cycle keeps pending[0]=1.
REQ-042 Scenario 6: assert rst_n=0 in SERVICE -> io_interrupt, pending and mask immediately 0 and d_bus Z; with IC_SYNC_EN, latency is 4 clocks.

Source files
------------

// File: rtl/ic_pkg.sv
// ic_pkg: shared types and default constants for interrupt_controller.
package ic_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } ic_state_e;

    localparam int          DEF_NUM_IRQ       = 8;
    localparam logic [15:0] DEF_VECTOR_BASE   = 16'h0010;
    localparam logic [15:0] DEF_VECTOR_STRIDE = 16'h0004;
    localparam logic [3:0]  DEF_MASK_ADDR     = 4'hF;

    // Vector address wraps at 16 bits.
    function automatic logic [15:0] vector_addr(input logic [15:0] base,
                                                input logic [15:0] stride,
                                                input logic [3:0]  idx);
        return base + (16'(idx) * stride);
    endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// interrupt_controller_if: CPU-side strobes, I/O address and interrupt request.
// The shared data bus is a plain inout port on the controller.
interface interrupt_controller_if;
    logic        io_interrupt;
    logic        io_store_retaddr;
    logic        io_push_retaddr;
    logic        io_push_ints;
    logic        io_push_int_addr;
    logic        io_write;
    logic [15:0] d_addr;

    modport master (
        input  io_interrupt,
        output io_store_retaddr, io_push_retaddr, io_push_ints,
        output io_push_int_addr, io_write, d_addr
    );

    modport slave (
        output io_interrupt,
        input  io_store_retaddr, io_push_retaddr, io_push_ints,
        input  io_push_int_addr, io_write, d_addr
    );
endinterface

// File: rtl/ic_prio_enc.sv
// ic_prio_enc: combinational lowest-index priority encoder (up to 16 inputs).
module ic_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] req_i,
    output logic [3:0]   idx_o,
    output logic         valid_o
);

    // Scan from the top down so the lowest set bit is written last.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = 4'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: rising-edge, maskable, non-nesting interrupt controller.
// Build macro IC_SYNC_EN: adds a two-flop synchronizer on each irq line.
//
// state   | meaning
// IDLE    | no enabled request pending
// REQ     | io_interrupt raised, waiting for the CPU to store its return address
// SERVICE | handler running; vector/return address readable on d_bus
module interrupt_controller
    import ic_pkg::*;
#(
    parameter int          NUM_IRQ       = DEF_NUM_IRQ,
    parameter logic [15:0] VECTOR_BASE   = DEF_VECTOR_BASE,
    parameter logic [15:0] VECTOR_STRIDE = DEF_VECTOR_STRIDE,
    parameter logic [3:0]  MASK_ADDR     = DEF_MASK_ADDR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_IRQ-1:0]    irq,
    interrupt_controller_if.slave bus,
    inout  wire  [15:0]           d_bus
);

    logic [NUM_IRQ-1:0] irq_s;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] enabled;
    logic [NUM_IRQ-1:0] clr;
    logic [15:0]        retaddr_q;
    logic [3:0]         active_q;
    logic [3:0]         enc_idx;
    logic               enc_valid;
    ic_state_e          state_q, state_d;
    logic               int_q;
    logic               take;
    logic [15:0]        dout;
    logic               drive_en;
    logic               unused_addr_hi;

    assign unused_addr_hi = ^bus.d_addr[15:4];

`ifdef IC_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_q, sync2_q;

    // Two-flop synchronizer for asynchronous irq sources.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq;
`endif

    assign enabled = pending_q & mask_q;

    ic_prio_enc #(.N(NUM_IRQ)) u_enc (
        .req_i   (enabled),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    // Next-state logic; losing every enabled request in REQ abandons the request.
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        unique case (state_q)
            IDLE:    if (enc_valid) state_d = REQ;
            REQ: begin
                if (!enc_valid) begin
                    state_d = IDLE;
                end else if (bus.io_store_retaddr) begin
                    state_d = SERVICE;
                    take    = 1'b1;
                end
            end
            SERVICE: if (bus.io_push_retaddr) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Clear the acknowledged line; a same-cycle edge still sets it again.
    always_comb begin
        clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr[i] = take && (enc_idx == 4'(i));
        end
        pending_d = (pending_q & ~clr) | (irq_s & ~irq_prev_q);
    end

    // Controller state, pending/mask registers and acknowledge capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            int_q      <= 1'b0;
            pending_q  <= '0;
            mask_q     <= '0;
            retaddr_q  <= '0;
            active_q   <= '0;
            irq_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            int_q      <= (state_d == REQ);
            pending_q  <= pending_d;
            irq_prev_q <= irq_s;
            if (bus.io_write && (bus.d_addr[3:0] == MASK_ADDR)) begin
                mask_q <= d_bus[NUM_IRQ-1:0];
            end
            if (take) begin
                retaddr_q <= d_bus;
                active_q  <= enc_idx;
            end
        end
    end

    assign bus.io_interrupt = int_q;

    // Read-back mux; one source at a time, bus released during reset.
    always_comb begin
        drive_en = rst_n & (bus.io_push_retaddr | bus.io_push_int_addr | bus.io_push_ints);
        dout     = '0;
        if (bus.io_push_retaddr) begin
            dout = retaddr_q;
        end else if (bus.io_push_int_addr) begin
            dout = vector_addr(VECTOR_BASE, VECTOR_STRIDE, active_q);
        end else if (bus.io_push_ints) begin
            dout = 16'(pending_q);
        end
    end

    assign d_bus = drive_en ? dout : 16'hzzzz;

endmodule
